// File: rtl/sad_min_engine_if.sv
// Bus bundle for sad_min_engine: window/frame stream in, tagged SAD and running minimum out.
// Handshake: frm_valid has no ready; a word is taken on every edge where frm_valid=1 and clear=0,
// and sad_valid is a one-cycle strobe qualifying sad_value/sad_tag with no back-pressure.
interface sad_min_engine_if #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int ROWS  = 4,
  parameter int TAG_W = 32
);
  localparam int DW    = LANES * PIX_W;
  localparam int SAD_W = PIX_W + $clog2(LANES * ROWS);

  logic             clear;
  logic             win_shift;
  logic [DW-1:0]    win_data;
  logic             frm_valid;
  logic [DW-1:0]    frm_data;
  logic [TAG_W-1:0] frm_tag;
  logic             sad_valid;
  logic [SAD_W-1:0] sad_value;
  logic [TAG_W-1:0] sad_tag;
  logic             min_valid;
  logic [SAD_W-1:0] min_value;
  logic [TAG_W-1:0] min_tag;

  modport master (
    output clear, win_shift, win_data, frm_valid, frm_data, frm_tag,
    input  sad_valid, sad_value, sad_tag, min_valid, min_value, min_tag
  );

  modport slave (
    input  clear, win_shift, win_data, frm_valid, frm_data, frm_tag,
    output sad_valid, sad_value, sad_tag, min_valid, min_value, min_tag
  );
endinterface

// File: rtl/sad_min_engine.sv
// Two-stage SAD engine: candidate = last ROWS-1 frame words plus the current one, compared
// against a ROWS-deep window; keeps the smallest SAD and its tag since the last clear.
module sad_min_engine #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int ROWS  = 4,
  parameter int TAG_W = 32
) (
  input logic             Clk,
  input logic             Reset,
  sad_min_engine_if.slave bus
);
  localparam int DW     = LANES * PIX_W;
  localparam int ROW_W  = PIX_W + $clog2(LANES);
  localparam int SAD_W  = PIX_W + $clog2(LANES * ROWS);
  localparam int FILL_W = $clog2(ROWS);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(ROWS - 1);

  logic [ROWS-1:0][DW-1:0]    win_q, win_d;
  logic [ROWS-2:0][DW-1:0]    frm_hist_q, frm_hist_d;
  logic [FILL_W-1:0]          fill_q, fill_d;
  logic [ROWS-1:0][ROW_W-1:0] row_sum_q, row_sum_d;
  logic [TAG_W-1:0]           tag1_q, tag1_d;
  logic                       v1_q, v1_d;
  logic [SAD_W-1:0]           sad_value_q, sad_value_d;
  logic [TAG_W-1:0]           sad_tag_q, sad_tag_d;
  logic                       sad_valid_q, sad_valid_d;
  logic                       min_valid_q, min_valid_d;
  logic [SAD_W-1:0]           min_value_q, min_value_d;
  logic [TAG_W-1:0]           min_tag_q, min_tag_d;

  logic [ROWS-1:0][DW-1:0] cand;
  logic [PIX_W-1:0]        pix_a, pix_b, pix_d;
  logic [SAD_W-1:0]        sad_sum;
  logic                    accept, complete;

  // clear takes priority over an incoming frame word
  assign accept   = bus.frm_valid & ~bus.clear;
  assign complete = accept & (fill_q == FILL_MAX);

  always_comb begin
    win_d      = win_q;
    frm_hist_d = frm_hist_q;
    fill_d     = fill_q;
    if (bus.win_shift) begin
      for (int k = 0; k < ROWS - 1; k++) win_d[k] = win_q[k+1];
      win_d[ROWS-1] = bus.win_data;
    end
    if (accept) begin
      for (int k = 0; k < ROWS - 2; k++) frm_hist_d[k] = frm_hist_q[k+1];
      frm_hist_d[ROWS-2] = bus.frm_data;
      if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
    end
    if (bus.clear) fill_d = '0;
  end

  // Stage 1: per-row absolute-difference sums against the pre-shift window
  always_comb begin
    pix_a     = '0;
    pix_b     = '0;
    pix_d     = '0;
    row_sum_d = '0;
    for (int k = 0; k < ROWS - 1; k++) cand[k] = frm_hist_q[k];
    cand[ROWS-1] = bus.frm_data;
    for (int r = 0; r < ROWS; r++) begin
      for (int l = 0; l < LANES; l++) begin
        pix_a = cand[r][l*PIX_W +: PIX_W];
        pix_b = win_q[r][l*PIX_W +: PIX_W];
        pix_d = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);
        row_sum_d[r] = row_sum_d[r] + ROW_W'(pix_d);
      end
    end
    v1_d   = complete;
    tag1_d = complete ? bus.frm_tag : tag1_q;
  end

  // Stage 2 and the minimum tracker
  always_comb begin
    sad_sum = '0;
    for (int r = 0; r < ROWS; r++) sad_sum = sad_sum + SAD_W'(row_sum_q[r]);
    sad_valid_d = v1_q & ~bus.clear;
    sad_value_d = v1_q ? sad_sum : sad_value_q;
    sad_tag_d   = v1_q ? tag1_q : sad_tag_q;
    min_valid_d = min_valid_q;
    min_value_d = min_value_q;
    min_tag_d   = min_tag_q;
    if (bus.clear) begin
      min_valid_d = 1'b0;
      min_value_d = '1;
    end else if (sad_valid_q && (!min_valid_q || sad_value_q < min_value_q)) begin
      min_valid_d = 1'b1;
      min_value_d = sad_value_q;
      min_tag_d   = sad_tag_q;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      win_q       <= '0;
      frm_hist_q  <= '0;
      fill_q      <= '0;
      row_sum_q   <= '0;
      tag1_q      <= '0;
      v1_q        <= 1'b0;
      sad_value_q <= '0;
      sad_tag_q   <= '0;
      sad_valid_q <= 1'b0;
      min_valid_q <= 1'b0;
      min_value_q <= '1;
      min_tag_q   <= '0;
    end else begin
      win_q       <= win_d;
      frm_hist_q  <= frm_hist_d;
      fill_q      <= fill_d;
      row_sum_q   <= row_sum_d;
      tag1_q      <= tag1_d;
      v1_q        <= v1_d;
      sad_value_q <= sad_value_d;
      sad_tag_q   <= sad_tag_d;
      sad_valid_q <= sad_valid_d;
      min_valid_q <= min_valid_d;
      min_value_q <= min_value_d;
      min_tag_q   <= min_tag_d;
    end
  end

  assign bus.sad_valid = sad_valid_q;
  assign bus.sad_value = sad_value_q;
  assign bus.sad_tag   = sad_tag_q;
  assign bus.min_valid = min_valid_q;
  assign bus.min_value = min_value_q;
  assign bus.min_tag   = min_tag_q;
endmodule

// File: tb/tb_sad_min_engine.sv
// Bench for sad_min_engine: default instance checked against a behavioural SAD/minimum model,
// plus a LANES=8, ROWS=2 instance for the parameter sweep.
module tb_sad_min_engine;
  localparam int EW = 76;  // {due cycle[31:0], tag[31:0], sad[11:0]}

  logic Clk;
  logic Reset;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp2_q[$];

  logic [31:0] m_win[4];
  logic [31:0] m_frm[3];
  int          m_fill;
  logic        m_min_v;
  logic [11:0] m_min;
  logic [31:0] m_min_tag;

  sad_min_engine_if #(.PIX_W(8), .LANES(4), .ROWS(4), .TAG_W(32)) ifc ();
  sad_min_engine_if #(.PIX_W(8), .LANES(8), .ROWS(2), .TAG_W(32)) ifc2 ();

  sad_min_engine #(.PIX_W(8), .LANES(4), .ROWS(4), .TAG_W(32)) dut (
    .Clk(Clk), .Reset(Reset), .bus(ifc.slave)
  );
  sad_min_engine #(.PIX_W(8), .LANES(8), .ROWS(2), .TAG_W(32)) dut2 (
    .Clk(Clk), .Reset(Reset), .bus(ifc2.slave)
  );

  // clock / cycle count
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  initial cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int abs_sum(input logic [63:0] a, input logic [63:0] b, input int lanes);
    int s = 0;
    for (int l = 0; l < lanes; l++) begin
      int x = int'(a[l*8 +: 8]);
      int y = int'(b[l*8 +: 8]);
      s += (x > y) ? (x - y) : (y - x);
    end
    return s;
  endfunction

  task automatic model_reset_all();
    for (int k = 0; k < 4; k++) m_win[k] = '0;
    for (int k = 0; k < 3; k++) m_frm[k] = '0;
    m_fill    = 0;
    m_min_v   = 1'b0;
    m_min     = 12'hFFF;
    m_min_tag = '0;
    exp_q.delete();
  endtask

  // driver for the default instance; expectations are pushed as the stimulus is applied
  task automatic drive(input logic shift, input logic [31:0] wd, input logic fv,
                       input logic [31:0] fd, input logic [31:0] tag, input logic clr);
    int s;
    @(posedge Clk);
    #2;
    ifc.win_shift = shift;
    ifc.win_data  = wd;
    ifc.frm_valid = fv;
    ifc.frm_data  = fd;
    ifc.frm_tag   = tag;
    ifc.clear     = clr;
    if (fv && !clr) begin
      if (m_fill == 3) begin
        s = abs_sum({32'd0, m_frm[0]}, {32'd0, m_win[0]}, 4)
          + abs_sum({32'd0, m_frm[1]}, {32'd0, m_win[1]}, 4)
          + abs_sum({32'd0, m_frm[2]}, {32'd0, m_win[2]}, 4)
          + abs_sum({32'd0, fd},       {32'd0, m_win[3]}, 4);
        exp_q.push_back({32'(cyc + 2), tag, 12'(s)});
      end
      m_frm[0] = m_frm[1];
      m_frm[1] = m_frm[2];
      m_frm[2] = fd;
      if (m_fill < 3) m_fill++;
    end
    if (clr) begin
      m_fill = 0;
      while (exp_q.size() > 0 && int'(exp_q[exp_q.size()-1][75:44]) > cyc) void'(exp_q.pop_back());
    end
    if (shift) begin
      m_win[0] = m_win[1];
      m_win[1] = m_win[2];
      m_win[2] = m_win[3];
      m_win[3] = wd;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic drive2(input logic shift, input logic [63:0] wd, input logic fv,
                        input logic [63:0] fd, input logic [31:0] tag,
                        input logic push, input logic [11:0] exp_sad);
    @(posedge Clk);
    #2;
    ifc2.win_shift = shift;
    ifc2.win_data  = wd;
    ifc2.frm_valid = fv;
    ifc2.frm_data  = fd;
    ifc2.frm_tag   = tag;
    if (push) exp2_q.push_back({32'(cyc + 2), tag, exp_sad});
  endtask

  // scoreboard: SAD stream and running minimum of the default instance
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    logic          got;
    if (Reset) begin
      got = 1'b0;
      e   = '0;
      if (ifc.sad_valid) begin
        if (exp_q.size() == 0) begin
          check("sad_unexpected", 64'(ifc.sad_tag), 64'hDEAD);
        end else begin
          e   = exp_q.pop_front();
          got = 1'b1;
          check("sad_cycle", 64'(cyc), 64'(e[75:44]));
          check("sad_value", 64'(ifc.sad_value), 64'(e[11:0]));
          check("sad_tag",   64'(ifc.sad_tag),   64'(e[43:12]));
        end
      end else if (exp_q.size() > 0 && int'(exp_q[0][75:44]) <= cyc) begin
        e = exp_q.pop_front();
        check("sad_missing", 64'(cyc), 64'(e[75:44]) - 64'd1);
      end
      check("min_valid", 64'(ifc.min_valid), 64'(m_min_v));
      check("min_value", 64'(ifc.min_value), 64'(m_min));
      check("min_tag",   64'(ifc.min_tag),   64'(m_min_tag));
      if (ifc.clear) begin
        m_min_v = 1'b0;
        m_min   = 12'hFFF;
      end else if (got && (!m_min_v || e[11:0] < m_min)) begin
        m_min_v   = 1'b1;
        m_min     = e[11:0];
        m_min_tag = e[43:12];
      end
    end
  end

  // scoreboard for the sweep instance
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    if (Reset) begin
      if (ifc2.sad_valid) begin
        if (exp2_q.size() == 0) begin
          check("sweep_unexpected", 64'(ifc2.sad_tag), 64'hDEAD);
        end else begin
          e = exp2_q.pop_front();
          check("sweep_cycle", 64'(cyc), 64'(e[75:44]));
          check("sweep_value", 64'(ifc2.sad_value), 64'(e[11:0]));
          check("sweep_tag",   64'(ifc2.sad_tag),   64'(e[43:12]));
        end
      end else if (exp2_q.size() > 0 && int'(exp2_q[0][75:44]) <= cyc) begin
        e = exp2_q.pop_front();
        check("sweep_missing", 64'(cyc), 64'(e[75:44]) - 64'd1);
      end
    end
  end

  task automatic check_reset_outputs(input string where);
    check({where, "_sad_valid"}, 64'(ifc.sad_valid), 64'd0);
    check({where, "_sad_value"}, 64'(ifc.sad_value), 64'd0);
    check({where, "_sad_tag"},   64'(ifc.sad_tag),   64'd0);
    check({where, "_min_valid"}, 64'(ifc.min_valid), 64'd0);
    check({where, "_min_value"}, 64'(ifc.min_value), 64'hFFF);
    check({where, "_min_tag"},   64'(ifc.min_tag),   64'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    model_reset_all();
    ifc.clear = 0; ifc.win_shift = 0; ifc.win_data = '0;
    ifc.frm_valid = 0; ifc.frm_data = '0; ifc.frm_tag = '0;
    ifc2.clear = 0; ifc2.win_shift = 0; ifc2.win_data = '0;
    ifc2.frm_valid = 0; ifc2.frm_data = '0; ifc2.frm_tag = '0;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #1 check_reset_outputs("reset");
    check("reset_sweep_valid", 64'(ifc2.sad_valid), 64'd0);
    #1 Reset = 1'b1;

    // basic SAD: 0x03 - 0x01 over 16 pixels = 32
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h01010101, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 32'h03030303, 32'h100 + 32'(4*i), 1'b0);
    idle(4);

    // sliding window with running minimum
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      drive(1'b0, '0, 1'b1, (i < 4) ? 32'h10101010 : 32'h0, 32'h200 + 32'(4*i), 1'b0);
    idle(4);

    // full-scale difference
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 32'h0, 32'h300 + 32'(4*i), 1'b0);
    idle(4);

    // tie: two candidates of SAD 64, min_tag stays on the first
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 32'h04040404, 32'h400 + 32'(4*i), 1'b0);
    idle(4);
    check("tie_min_tag", 64'(ifc.min_tag), 64'h40C);

    // clear colliding with sad_valid and frm_valid
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 32'h01010101, 32'h500 + 32'(4*i), 1'b0);
    idle(1);
    drive(1'b0, '0, 1'b1, 32'h01010101, 32'h5F0, 1'b1);
    idle(1);
    check("clear_min_valid", 64'(ifc.min_valid), 64'd0);
    check("clear_min_value", 64'(ifc.min_value), 64'hFFF);
    for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1, 32'h02020202, 32'h600 + 32'(4*i), 1'b0);
    idle(3);
    // clear one cycle after the completing word drops the in-flight result
    drive(1'b0, '0, 1'b1, 32'h01000000, 32'h700, 1'b0);
    drive(1'b0, '0, 1'b0, '0, '0, 1'b1);
    idle(4);

    // async reset mid-stream
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h0A0B0C0D, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 6; i++) drive(1'b0, '0, 1'b1, 32'h01020304, 32'h800 + 32'(4*i), 1'b0);
    @(posedge Clk);
    #3 Reset = 1'b0;
    ifc.win_shift = 0; ifc.frm_valid = 0; ifc.clear = 0;
    #1 check_reset_outputs("async");
    model_reset_all();
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, '0, 1'b1, 32'h05050505, 32'h900 + 32'(4*i), 1'b0);
    idle(3);
    check("async_no_early_sad", 64'(exp_q.size()), 64'd0);
    drive(1'b0, '0, 1'b1, 32'h01010101, 32'h90C, 1'b0);
    idle(4);

    // parameter sweep: LANES=8, ROWS=2
    drive2(1'b1, 64'h0102030405060708, 1'b0, '0, '0, 1'b0, '0);
    drive2(1'b1, 64'h0102030405060708, 1'b0, '0, '0, 1'b0, '0);
    drive2(1'b0, '0, 1'b1, 64'h0102030405060708, 32'hA00, 1'b0, '0);
    drive2(1'b0, '0, 1'b1, 64'h0102030405060708, 32'hA04, 1'b1, 12'd0);
    drive2(1'b0, '0, 1'b1, 64'h0102030905060708, 32'hA08, 1'b1, 12'd5);
    drive2(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    repeat (4) @(posedge Clk);
    #1;

    check("drain_main",  64'(exp_q.size()),  64'd0);
    check("drain_sweep", 64'(exp2_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sad_min_engine.md
Name: sad_min_engine

Overview:
- Parametrised, pipelined sum-of-absolute-differences engine with running-minimum tracking, for the motion-estimation path of the MIPS32 core.
- Holds a ROWS x LANES reference window and streams frame words one per cycle, forming a candidate from the last ROWS frame words.
- Emits one tagged SAD per candidate after a fixed 2-cycle latency.
- Keeps the smallest SAD seen since the last clear, with its tag, for readback by the SAD load instruction.

Parameters:
- PIX_W, 8: bits per unsigned pixel.
- LANES, 4: pixels per data word.
- ROWS, 4: words per window/candidate (minimum 2).
- TAG_W, 32: width of the tag carried with each candidate (address from ALU result).
- SAD_W, derived as PIX_W + clog2(LANES*ROWS), 12 by default: width of SAD and minimum values; not overridable.

Ports:
- Clk, input, 1: clock; all state updates on the rising edge.
- Reset, input, 1: asynchronous, active-low reset.
- clear, input, 1: synchronous start of a new search.
- win_shift, input, 1: shift win_data into the window register.
- win_data, input, LANES*PIX_W: window word.
- frm_valid, input, 1: frame word present this cycle.
- frm_data, input, LANES*PIX_W: frame word.
- frm_tag, input, TAG_W: tag of frm_data.
- sad_valid, output, 1: sad_value and sad_tag are valid this cycle.
- sad_value, output, SAD_W: SAD of the completed candidate.
- sad_tag, output, TAG_W: tag of the word that completed the candidate.
- min_valid, output, 1: at least one SAD has been accepted since the last clear.
- min_value, output, SAD_W: smallest SAD since the last clear.
- min_tag, output, TAG_W: tag of min_value.

Behaviour:
- Lane indexing: lane i occupies bits [i*PIX_W +: PIX_W]. Pixels are unsigned.
- Window register W[0..ROWS-1]:
  - On win_shift: W[k] <= W[k+1], and W[ROWS-1] <= win_data.
  - Unaffected by clear. Reset value is all zeros.
- Frame history F[0..ROWS-2]:
  - On an accepted frm_valid: same shift pattern, with frm_data entering F[ROWS-2].
  - Reset value is all zeros; not cleared by clear.
- Candidate C = {F[0], ..., F[ROWS-2], frm_data}. C[k] is compared with W[k] using the window value before any same-cycle win_shift.
- Fill counter:
  - Counts accepted frame words and saturates at ROWS-1.
  - A candidate is complete when frm_valid=1 and the counter has already reached ROWS-1.
  - Reset and clear set the counter to 0.
- Pipeline stage 1 (edge after acceptance): register the per-row sums of LANES absolute differences (width PIX_W + clog2(LANES)), plus the tag and a valid bit.
- Pipeline stage 2 (next edge): register the sum of the row sums into sad_value, and set sad_tag and sad_valid.
- Latency: the word that completes a candidate at cycle t produces sad_valid at cycle t+2. Throughput is 1 SAD/cycle with no stalls.
- Arithmetic: exact, no saturation. The maximum value (2^PIX_W - 1)*LANES*ROWS fits in SAD_W.
- Min tracker:
  - On the edge where sad_valid=1, update if min_valid=0 or sad_value < min_value: min_value <= sad_value, min_tag <= sad_tag, min_valid <= 1. Strictly less-than, so ties keep the earlier tag.
  - The update is visible one cycle after sad_valid.
- clear:
  - Zeroes both pipeline valid bits, so in-flight SADs are dropped and never reach the tracker.
  - Sets the fill counter to 0, min_valid to 0, and min_value to all ones. min_tag is held.
  - When asserted together with frm_valid, clear wins: the frame word is not accepted and F is not shifted.
  - When asserted together with a sad_valid update, clear wins.
- Mid-stream win_shift takes effect for candidates accepted in later cycles. In-flight SADs are unaffected.
- Reset (async, Reset=0):
  - Outputs: sad_valid=0, sad_value=0, sad_tag=0, min_valid=0, min_value all ones, min_tag=0.
  - Internal state: pipeline, fill counter, W and F all cleared.
  - Deassertion is sampled on Clk. Reset during streaming discards all in-flight results.

Test Plan:
- Basic SAD: default params; shift window words 0x01010101 x4; stream frame words 0x03030303 x4 with tags 0x100, 0x104, 0x108, 0x10C -> exactly one sad_valid, 2 cycles after the 4th word, with sad_value=32 and sad_tag=0x10C; min_value=32 one cycle later.
- Sliding and min: window all 0x00; stream frame words 0x10101010, 0x10101010, 0x10101010, 0x10101010, 0x00000000, 0x00000000 -> SADs 256, 192, 128 on consecutive cycles; min_value=128 with the tag of the 6th word.
- Tie and abs: window lanes 0xFF, frame lanes 0x00 give 4080 (full-scale, no overflow). Then two candidates with equal SAD 64 -> min_tag stays on the first.
- Clear collision: assert clear on the cycle sad_valid=1 and also with frm_valid=1 -> min_valid=0, min_value=0xFFF, and the next SAD needs 4 fresh words.
- Async reset mid-stream: pull Reset low between clock edges during streaming -> outputs return to reset values immediately; no sad_valid after release until 4 new words are accepted.
- Parameter sweep: PIX_W=8, LANES=8, ROWS=2 -> SAD_W=12; identical frame and window words give SAD 0; a single-lane difference of 5 gives SAD 5.
